debug_event_writer: RTL and testbench

- Bus initiator for the simulation debug port of a PE. Hardware event sources (UART byte, scheduler trace, pipe/request/available trace, halt) post tagged events.
- Events are buffered in a FIFO and serialised into single-cycle memory-mapped writes on the en/we/addr/data debug interface.
- Bus ownership is shared with the CPU via a grant input.
- A halt event is always the last write issued; the block then locks until reset.

---
 rtl/debug_event_writer.sv | 210 +++++++++++++++++++++
 tb/tb_debug_event_writer.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/debug_event_writer.sv
// debug_event_writer: buffers tagged hardware events in a small FIFO and
// replays them as single-cycle writes on the en/we/addr/data debug port.
// The CPU shares the port; a write only completes in a cycle with gnt_i=1.
// A halt event is the last write ever issued; the block then locks until reset.
module debug_event_writer #(
    parameter int FIFO_DEPTH = 8,
    parameter bit LOSSY      = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        evt_valid_i,
    output logic        evt_ready_o,
    input  logic [3:0]  evt_kind_i,
    input  logic [31:0] evt_data_i,
    input  logic        gnt_i,
    output logic        en_o,
    output logic        we_o,
    output logic [23:0] addr_o,
    output logic [31:0] data_o,
    output logic        halted_o,
    output logic        err_o,
    output logic [15:0] drop_cnt_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int EW = 56;
    localparam logic [23:0] HALT_ADDR = 24'h000004;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t          state_q;
    logic            en_q;
    logic [23:0]     addr_q;
    logic [31:0]     data_q;
    logic            halted_q;
    logic            err_q, err_d;

    logic [EW-1:0]   mem_q [FIFO_DEPTH];
    logic [AW:0]     wr_ptr_q, wr_ptr_d;
    logic [AW:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count;
    logic            full, empty, more;
    logic            legal, accept, push, pop;
    logic [AW-1:0]   rd_idx;
    logic [EW-1:0]   rd_entry;

    // Kind-to-address decode; illegal kinds never reach the FIFO.
    function automatic logic [23:0] map_kind(input logic [3:0] kind);
        logic [23:0] a;
        case (kind)
            4'd0:    a = 24'h000000;
            4'd1:    a = 24'h000004;
            4'd2:    a = 24'h000010;
            4'd3:    a = 24'h000020;
            4'd4:    a = 24'h000024;
            4'd5:    a = 24'h000030;
            4'd6:    a = 24'h000034;
            4'd7:    a = 24'h000040;
            4'd8:    a = 24'h000044;
            default: a = 24'h000000;
        endcase
        return a;
    endfunction

    // Occupancy flags and handshake, all derived from registered state so
    // ready has no path from gnt_i.
    always_comb begin
        count       = wr_ptr_q - rd_ptr_q;
        empty       = (wr_ptr_q == rd_ptr_q);
        full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        // More than the in-flight head is buffered.
        more        = (count > (AW+1)'(1));
        legal       = (evt_kind_i <= 4'd8);
        evt_ready_o = (state_q != HALTED) && (LOSSY ? 1'b1 : !full);
        accept      = evt_valid_i && evt_ready_o;
        push        = accept && legal && !full;
        pop         = (state_q == ISSUE) && gnt_i;
        // While issuing, the head is already on the bus; look one ahead.
        rd_idx      = (state_q == ISSUE) ? (rd_ptr_q[AW-1:0] + AW'(1))
                                         : rd_ptr_q[AW-1:0];
        rd_entry    = mem_q[rd_idx];
    end

    // Next pointer values; a halted block flushes whatever is left.
    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push);
        rd_ptr_d = rd_ptr_q;
        if (state_q == HALTED) begin
            rd_ptr_d = wr_ptr_q;
        end else if (pop) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
        err_d = err_q | (accept && !legal);
    end

    // FIFO storage: mapped address and payload, written on accepted pushes.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {map_kind(evt_kind_i), evt_data_i};
        end
    end

    // Pointer and sticky error registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            err_q    <= err_d;
        end
    end

    // Drop counter exists only when the block never back-pressures.
    generate
        if (LOSSY) begin : gen_lossy
            logic [15:0] drop_q, drop_d;

            // Count legal events that arrive while the FIFO is full.
            always_comb begin
                drop_d = drop_q;
                if (accept && legal && full && (drop_q != 16'hFFFF)) begin
                    drop_d = drop_q + 16'd1;
                end
            end

            // Saturating drop counter register.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    drop_q <= '0;
                end else begin
                    drop_q <= drop_d;
                end
            end

            assign drop_cnt_o = drop_q;
        end else begin : gen_strict
            assign drop_cnt_o = '0;
        end
    endgenerate

    // Bus sequencer: loads the FIFO head, holds it until granted, streams
    // back-to-back while data remains, and locks after the halt write.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            en_q     <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        en_q    <= 1'b1;
                        addr_q  <= rd_entry[EW-1:32];
                        data_q  <= rd_entry[31:0];
                        state_q <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (gnt_i) begin
                        if (addr_q == HALT_ADDR) begin
                            en_q     <= 1'b0;
                            addr_q   <= '0;
                            data_q   <= '0;
                            halted_q <= 1'b1;
                            state_q  <= HALTED;
                        end else if (more) begin
                            addr_q <= rd_entry[EW-1:32];
                            data_q <= rd_entry[31:0];
                        end else begin
                            en_q    <= 1'b0;
                            addr_q  <= '0;
                            data_q  <= '0;
                            state_q <= IDLE;
                        end
                    end
                end
                HALTED: begin
                    en_q     <= 1'b0;
                    addr_q   <= '0;
                    data_q   <= '0;
                    halted_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    en_q    <= 1'b0;
                    addr_q  <= '0;
                    data_q  <= '0;
                end
            endcase
        end
    end

    assign en_o     = en_q;
    assign we_o     = en_q;
    assign addr_o   = addr_q;
    assign data_o   = data_q;
    assign halted_o = halted_q;
    assign err_o    = err_q;

endmodule

// File: tb/tb_debug_event_writer.sv
// Bench for debug_event_writer: a back-pressuring and a lossy instance share
// one stimulus stream; each is checked every cycle against a queue model.
module tb_debug_event_writer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        evt_valid = 1'b0;
    logic [3:0]  evt_kind = 4'd0;
    logic [31:0] evt_data = 32'd0;
    logic        gnt = 1'b0;

    logic        ready_w  [2];
    logic        en_w     [2];
    logic        we_w     [2];
    logic [23:0] addr_w   [2];
    logic [31:0] data_w   [2];
    logic        halted_w [2];
    logic        err_w    [2];
    logic [15:0] drop_w   [2];

    int vectors = 0;
    int miscompares = 0;

    // Reference model state: queue contents (head is the entry on the bus
    // while busy), bus-busy flag, halted/err flags and drop count.
    logic [55:0] mq [2][DEPTH];
    int          mcnt  [2];
    bit          mbusy [2];
    bit          mhalt [2];
    bit          merr  [2];
    int          mdrop [2];

    bit          capture = 1'b0;
    logic [23:0] log_addr [$];

    always #5 clk = ~clk;

    debug_event_writer #(.FIFO_DEPTH(DEPTH), .LOSSY(1'b0)) dut_strict (
        .clk_i(clk), .rst_ni(rst_n),
        .evt_valid_i(evt_valid), .evt_ready_o(ready_w[0]),
        .evt_kind_i(evt_kind), .evt_data_i(evt_data), .gnt_i(gnt),
        .en_o(en_w[0]), .we_o(we_w[0]), .addr_o(addr_w[0]), .data_o(data_w[0]),
        .halted_o(halted_w[0]), .err_o(err_w[0]), .drop_cnt_o(drop_w[0])
    );

    debug_event_writer #(.FIFO_DEPTH(DEPTH), .LOSSY(1'b1)) dut_lossy (
        .clk_i(clk), .rst_ni(rst_n),
        .evt_valid_i(evt_valid), .evt_ready_o(ready_w[1]),
        .evt_kind_i(evt_kind), .evt_data_i(evt_data), .gnt_i(gnt),
        .en_o(en_w[1]), .we_o(we_w[1]), .addr_o(addr_w[1]), .data_o(data_w[1]),
        .halted_o(halted_w[1]), .err_o(err_w[1]), .drop_cnt_o(drop_w[1])
    );

    function automatic logic [23:0] kind_addr(input logic [3:0] k);
        case (k)
            4'd0: return 24'h000000;
            4'd1: return 24'h000004;
            4'd2: return 24'h000010;
            4'd3: return 24'h000020;
            4'd4: return 24'h000024;
            4'd5: return 24'h000030;
            4'd6: return 24'h000034;
            4'd7: return 24'h000040;
            4'd8: return 24'h000044;
            default: return 24'h000000;
        endcase
    endfunction

    task automatic chk(input string name, input int m, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s dut%0d at %0t: actual=%0h required=%0h", name, m, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mcnt[m] = 0; mbusy[m] = 0; mhalt[m] = 0; merr[m] = 0; mdrop[m] = 0;
        end
    endtask

    // Compare every DUT output of both instances with the model.
    task automatic check_models();
        for (int m = 0; m < 2; m++) begin
            logic [23:0] ea;
            logic [31:0] ed;
            logic        er;
            ea = mbusy[m] ? mq[m][0][55:32] : 24'h0;
            ed = mbusy[m] ? mq[m][0][31:0]  : 32'h0;
            er = !mhalt[m] && ((m == 1) || (mcnt[m] < DEPTH));
            chk("en",     m, 64'(en_w[m]),     64'(mbusy[m]));
            chk("we",     m, 64'(we_w[m]),     64'(mbusy[m]));
            chk("addr",   m, 64'(addr_w[m]),   64'(ea));
            chk("data",   m, 64'(data_w[m]),   64'(ed));
            chk("halted", m, 64'(halted_w[m]), 64'(mhalt[m]));
            chk("err",    m, 64'(err_w[m]),    64'(merr[m]));
            chk("ready",  m, 64'(ready_w[m]),  64'(er));
            chk("drop",   m, 64'(drop_w[m]),   64'((m == 1) ? mdrop[m] : 0));
        end
    endtask

    // Predict the effect of the coming clock edge from the current inputs.
    task automatic model_step();
        for (int m = 0; m < 2; m++) begin
            bit full, rdy, acc, legal, pushing;
            logic [55:0] head;
            full    = (mcnt[m] == DEPTH);
            rdy     = !mhalt[m] && ((m == 1) || !full);
            acc     = evt_valid && rdy;
            legal   = (evt_kind <= 4'd8);
            pushing = acc && legal && !full;
            if (acc && !legal) merr[m] = 1;
            if ((m == 1) && acc && legal && full && (mdrop[m] < 65535)) mdrop[m]++;
            if (mbusy[m] && gnt) begin
                head = mq[m][0];
                for (int i = 0; i < DEPTH - 1; i++) mq[m][i] = mq[m][i+1];
                mcnt[m]--;
                if (head[55:32] == 24'h4) begin
                    mhalt[m] = 1; mbusy[m] = 0; mcnt[m] = 0;
                end else begin
                    mbusy[m] = (mcnt[m] > 0);
                end
            end else if (!mbusy[m] && !mhalt[m] && (mcnt[m] > 0)) begin
                mbusy[m] = 1;
            end
            if (pushing && !mhalt[m]) begin
                mq[m][mcnt[m]] = {kind_addr(evt_kind), evt_data};
                mcnt[m]++;
            end
        end
    endtask

    // One clock: drive inputs at the falling edge, clock, check at next fall.
    task automatic step(input logic v, input logic [3:0] k, input logic [31:0] d, input logic g);
        evt_valid = v; evt_kind = k; evt_data = d; gnt = g;
        if (capture && en_w[0] && g) log_addr.push_back(addr_w[0]);
        model_step();
        @(negedge clk);
        check_models();
    endtask

    task automatic do_reset();
        evt_valid = 0; gnt = 0;
        rst_n = 0;
        model_reset();
        #1;
        check_models();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
    endtask

    typedef struct {
        logic [3:0]  kind;
        logic [31:0] data;
        logic        exp_en;
        logic [23:0] exp_addr;
        logic        exp_err;
    } vec_t;

    vec_t tab [11];
    logic [3:0]  burst_kind [8];
    logic [23:0] burst_addr [8];

    initial begin
        tab[0]  = '{4'd0,  32'h00000041, 1'b1, 24'h000000, 1'b0};
        tab[1]  = '{4'd2,  32'h11111111, 1'b1, 24'h000010, 1'b0};
        tab[2]  = '{4'd3,  32'h22222222, 1'b1, 24'h000020, 1'b0};
        tab[3]  = '{4'd4,  32'h33333333, 1'b1, 24'h000024, 1'b0};
        tab[4]  = '{4'd5,  32'h44444444, 1'b1, 24'h000030, 1'b0};
        tab[5]  = '{4'd6,  32'h55555555, 1'b1, 24'h000034, 1'b0};
        tab[6]  = '{4'd7,  32'h66666666, 1'b1, 24'h000040, 1'b0};
        tab[7]  = '{4'd8,  32'h77777777, 1'b1, 24'h000044, 1'b0};
        tab[8]  = '{4'd9,  32'h88888888, 1'b0, 24'h000000, 1'b1};
        tab[9]  = '{4'd12, 32'h99999999, 1'b0, 24'h000000, 1'b1};
        tab[10] = '{4'd15, 32'hAAAAAAAA, 1'b0, 24'h000000, 1'b1};
        burst_kind = '{4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd2, 4'd0};
        burst_addr = '{24'h20, 24'h24, 24'h30, 24'h34, 24'h40, 24'h44, 24'h10, 24'h00};

        // Reset state.
        model_reset();
        @(negedge clk);
        check_models();
        @(negedge clk);
        rst_n = 1;

        // Single events through the kind map, with gnt tied high.
        for (int i = 0; i < 11; i++) begin
            step(1, tab[i].kind, tab[i].data, 1);
            step(0, 4'd0, 32'd0, 1);
            chk("tab_en",   0, 64'(en_w[0]),   64'(tab[i].exp_en));
            chk("tab_addr", 0, 64'(addr_w[0]), 64'(tab[i].exp_addr));
            chk("tab_data", 0, 64'(data_w[0]), 64'(tab[i].exp_en ? tab[i].data : 32'd0));
            chk("tab_err",  0, 64'(err_w[0]),  64'(tab[i].exp_err));
            step(0, 4'd0, 32'd0, 1);
            chk("tab_en_after", 0, 64'(en_w[0]), 64'd0);
            $display("vector %0d: kind=%0d addr=%06h en=%0b err=%0b", i, tab[i].kind, addr_w[0], tab[i].exp_en, err_w[0]);
        end
        do_reset();

        // Back-to-back burst of eight events.
        capture = 1; log_addr.delete();
        for (int i = 0; i < 8; i++) step(1, burst_kind[i], 32'(i), 1);
        for (int i = 0; i < 6; i++) step(0, 4'd0, 32'd0, 1);
        capture = 0;
        chk("burst_len", 0, 64'(log_addr.size()), 64'd8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) chk("burst_addr", 0, 64'(log_addr[i]), 64'(burst_addr[i]));
        $display("burst: %0d writes issued", log_addr.size());

        // Grant withheld for five cycles while a write is pending.
        step(1, 4'd5, 32'h0000CAFE, 0);
        step(0, 4'd0, 32'd0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("hold_en",   0, 64'(en_w[0]),   64'd1);
            chk("hold_addr", 0, 64'(addr_w[0]), 64'h30);
            chk("hold_data", 0, 64'(data_w[0]), 64'hCAFE);
            step(0, 4'd0, 32'd0, 0);
        end
        step(0, 4'd0, 32'd0, 1);
        chk("hold_done", 0, 64'(en_w[0]), 64'd0);
        $display("hold: write completed after grant");

        // Fill with grant low: strict instance back-pressures, lossy drops.
        for (int i = 0; i < 6; i++) step(1, 4'(2 + i), 32'(100 + i), 0);
        chk("full_ready", 0, 64'(ready_w[0]), 64'd0);
        chk("full_drop",  1, 64'(drop_w[1]),  64'd2);
        for (int i = 0; i < 8; i++) step(0, 4'd0, 32'd0, 1);
        $display("fill: strict ready=%0b lossy drops=%0d", ready_w[0], drop_w[1]);

        // SCHED, HALT, UART: halt is the last write and locks the block.
        capture = 1; log_addr.delete();
        step(1, 4'd2, 32'h0000005C, 1);
        step(1, 4'd1, 32'h0000DEAD, 1);
        step(1, 4'd0, 32'h00000055, 1);
        for (int i = 0; i < 6; i++) step(1, 4'd0, 32'h00000056, 1);
        capture = 0;
        chk("halt_len",  0, 64'(log_addr.size()), 64'd2);
        if (log_addr.size() >= 2) begin
            chk("halt_first",  0, 64'(log_addr[0]), 64'h10);
            chk("halt_second", 0, 64'(log_addr[1]), 64'h04);
        end
        chk("halted",      0, 64'(halted_w[0]), 64'd1);
        chk("halt_ready",  0, 64'(ready_w[0]),  64'd0);
        chk("halt_ready",  1, 64'(ready_w[1]),  64'd0);
        $display("halt: %0d writes, halted=%0b", log_addr.size(), halted_w[0]);
        do_reset();

        // Illegal kind, then reset while a write is on the bus.
        step(1, 4'd12, 32'h12, 1);
        step(0, 4'd0, 32'd0, 1);
        step(0, 4'd0, 32'd0, 1);
        chk("illegal_en",  0, 64'(en_w[0]),  64'd0);
        chk("illegal_err", 0, 64'(err_w[0]), 64'd1);
        step(1, 4'd3, 32'h77, 0);
        step(0, 4'd0, 32'd0, 0);
        chk("pre_reset_en", 0, 64'(en_w[0]), 64'd1);
        rst_n = 0;
        #1;
        chk("rst_en",   0, 64'(en_w[0]),   64'd0);
        chk("rst_addr", 0, 64'(addr_w[0]), 64'd0);
        chk("rst_data", 0, 64'(data_w[0]), 64'd0);
        chk("rst_err",  0, 64'(err_w[0]),  64'd0);
        $display("reset: outputs cleared en=%0b", en_w[0]);
        do_reset();

        // Randomised traffic against the model, with periodic resets.
        for (int it = 0; it < 3000; it++) begin
            if (it % 250 == 249) begin
                do_reset();
            end else begin
                logic [3:0] k;
                int r;
                r = $urandom_range(0, 199);
                if (r == 0) k = 4'd1;
                else if (r < 10) k = 4'(9 + $urandom_range(0, 6));
                else begin
                    int x;
                    x = $urandom_range(0, 7);
                    k = (x == 0) ? 4'd0 : 4'(x + 1);
                end
                step(1'($urandom_range(0, 1)), k, $urandom, 1'($urandom_range(0, 99) < 60));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
